// File: rtl/instr_decoder.sv
// Three-cycle decode/issue controller (IDLE -> EXEC -> WB) driving the ALU and register file.
// Optional trap on undefined opcodes: define INSTR_DECODER_ILLEGAL_TRAP_EN.
module instr_decoder #(
    parameter int WIDTH         = 16,
    parameter int ALU_CONT_BITS = 6
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic [15:0]              instr,
    input  logic                     instr_valid,
    output logic                     instr_ready,
    output logic [3:0]               rf_raddr_a,
    output logic [3:0]               rf_raddr_b,
    input  logic [WIDTH-1:0]         rf_rdata_a,
    input  logic [WIDTH-1:0]         rf_rdata_b,
    output logic [WIDTH-1:0]         alu_a,
    output logic [WIDTH-1:0]         alu_b,
    output logic [ALU_CONT_BITS-1:0] alu_cont,
    input  logic [WIDTH-1:0]         alu_out,
    input  logic [WIDTH-1:0]         psr_flags,
    output logic                     rf_we,
    output logic [3:0]               rf_waddr,
    output logic [WIDTH-1:0]         rf_wdata,
    output logic [WIDTH-1:0]         psr,
    output logic                     branch_valid,
    output logic                     branch_taken,
    output logic [WIDTH-1:0]         branch_disp,
    output logic                     illegal_instr
);

    typedef enum logic [1:0] {IDLE, EXEC, WB} state_t;

    localparam logic [3:0] OP_RTYPE = 4'b0000;
    localparam logic [3:0] OP_SHIFT = 4'b1000;
    localparam logic [3:0] OP_BCOND = 4'b1100;
    localparam logic [3:0] OP_LUI   = 4'b1111;
    localparam logic [3:0] CODE_ADD = 4'b0101;
    localparam logic [3:0] CODE_SUB = 4'b1001;
    localparam logic [3:0] CODE_CMP = 4'b1011;
    localparam logic [WIDTH-1:0] CF_MASK  = WIDTH'(16'h0021);
    localparam logic [WIDTH-1:0] NZL_MASK = WIDTH'(16'h00C4);

    state_t            state_q, state_d;
    logic [15:0]       instr_q, instr_d;
    logic [WIDTH-1:0]  psr_q, psr_d;
    logic [WIDTH-1:0]  rf_wdata_q, rf_wdata_d;
    logic [3:0]        rf_waddr_q, rf_waddr_d;
    logic              rf_we_q, rf_we_d;
    logic              branch_valid_q, branch_valid_d;
    logic              branch_taken_q, branch_taken_d;
    logic [WIDTH-1:0]  branch_disp_q, branch_disp_d;

    logic [3:0] op, rd, ext;
    logic [7:0] imm;
    assign op  = instr_q[15:12];
    assign rd  = instr_q[11:8];
    assign ext = instr_q[7:4];
    assign imm = instr_q[7:0];

    function automatic logic is_alu_code(input logic [3:0] c);
        return c inside {4'b0001, 4'b0010, 4'b0011, 4'b0101, 4'b0110, 4'b1001, 4'b1011, 4'b1101};
    endfunction

    // Conditions come in complementary pairs; bit 0 of the code inverts the base test.
    function automatic logic cond_met(input logic [3:0] cond, input logic [WIDTH-1:0] p);
        logic base;
        case (cond[3:1])
            3'd0:    base = p[6];
            3'd1:    base = p[0];
            3'd2:    base = p[2];
            3'd3:    base = p[7];
            3'd4:    base = p[5];
            3'd5:    base = !p[2] && !p[6];
            3'd6:    base = !p[7] && !p[6];
            default: base = 1'b1;
        endcase
        return base ^ cond[0];
    endfunction

    logic                     dec_alu, dec_branch, dec_arith, dec_we, upd_cf, upd_nzl;
    logic [3:0]               arith_code;
    logic [ALU_CONT_BITS-1:0] dec_cont;
    logic [WIDTH-1:0]         dec_b;

    always_comb begin
        dec_alu    = 1'b0;
        dec_branch = 1'b0;
        dec_arith  = 1'b0;
        arith_code = 4'b0000;
        dec_cont   = '0;
        dec_b      = '0;
        case (op)
            OP_RTYPE: if (is_alu_code(ext)) begin
                dec_alu    = 1'b1;
                dec_arith  = 1'b1;
                arith_code = ext;
                dec_cont   = ALU_CONT_BITS'({2'b00, ext});
                dec_b      = rf_rdata_b;
            end
            OP_SHIFT: if (ext == 4'b0100) begin
                dec_alu  = 1'b1;
                dec_cont = ALU_CONT_BITS'(6'b100101);
                dec_b    = rf_rdata_b;
            end else if (ext[3:1] == 3'b000) begin
                dec_alu  = 1'b1;
                dec_cont = ALU_CONT_BITS'(6'b100101);
                dec_b    = {{(WIDTH-5){instr_q[4]}}, instr_q[4:0]};
            end
            OP_BCOND: dec_branch = 1'b1;
            OP_LUI: begin
                dec_alu  = 1'b1;
                dec_cont = ALU_CONT_BITS'(6'b111111);
                dec_b    = {{(WIDTH-8){1'b0}}, imm};
            end
            default: if (is_alu_code(op)) begin
                dec_alu    = 1'b1;
                dec_arith  = 1'b1;
                arith_code = op;
                dec_cont   = ALU_CONT_BITS'({2'b00, op});
                // AND/OR/XOR immediates are zero-extended, the rest sign-extended
                dec_b      = (op[3:2] == 2'b00) ? {{(WIDTH-8){1'b0}}, imm}
                                                : {{(WIDTH-8){imm[7]}}, imm};
            end
        endcase
    end

    assign upd_cf  = dec_arith && (arith_code == CODE_ADD || arith_code == CODE_SUB);
    assign upd_nzl = dec_arith && (arith_code == CODE_CMP);
    assign dec_we  = dec_alu && !upd_nzl;

    always_comb begin
        state_d        = state_q;
        instr_d        = instr_q;
        psr_d          = psr_q;
        rf_wdata_d     = rf_wdata_q;
        rf_waddr_d     = rf_waddr_q;
        rf_we_d        = 1'b0;
        branch_valid_d = 1'b0;
        branch_taken_d = 1'b0;
        branch_disp_d  = branch_disp_q;
        case (state_q)
            IDLE: if (instr_valid) begin
                instr_d = instr;
                state_d = EXEC;
            end
            EXEC: begin
                state_d        = WB;
                rf_wdata_d     = alu_out;
                rf_waddr_d     = rd;
                rf_we_d        = dec_we;
                branch_valid_d = dec_branch;
                branch_taken_d = dec_branch && cond_met(rd, psr_q);
                if (dec_branch)
                    branch_disp_d = {{(WIDTH-8){imm[7]}}, imm};
                if (upd_cf)
                    psr_d = (psr_q & ~CF_MASK) | (psr_flags & CF_MASK);
                else if (upd_nzl)
                    psr_d = (psr_q & ~NZL_MASK) | (psr_flags & NZL_MASK);
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q        <= IDLE;
            instr_q        <= '0;
            psr_q          <= '0;
            rf_wdata_q     <= '0;
            rf_waddr_q     <= '0;
            rf_we_q        <= 1'b0;
            branch_valid_q <= 1'b0;
            branch_taken_q <= 1'b0;
            branch_disp_q  <= '0;
        end else begin
            state_q        <= state_d;
            instr_q        <= instr_d;
            psr_q          <= psr_d;
            rf_wdata_q     <= rf_wdata_d;
            rf_waddr_q     <= rf_waddr_d;
            rf_we_q        <= rf_we_d;
            branch_valid_q <= branch_valid_d;
            branch_taken_q <= branch_taken_d;
            branch_disp_q  <= branch_disp_d;
        end
    end

`ifdef INSTR_DECODER_ILLEGAL_TRAP_EN
    logic illegal_q, illegal_d;
    assign illegal_d = (state_q == EXEC) && !dec_alu && !dec_branch;
    always_ff @(posedge clk) begin
        if (reset) illegal_q <= 1'b0;
        else       illegal_q <= illegal_d;
    end
    assign illegal_instr = illegal_q;
`else
    assign illegal_instr = 1'b0;
`endif

    // ALU is only driven during EXEC so idle cycles present a quiet datapath
    assign instr_ready  = (state_q == IDLE);
    assign rf_raddr_a   = rd;
    assign rf_raddr_b   = instr_q[3:0];
    assign alu_a        = (state_q == EXEC && dec_alu) ? rf_rdata_a : '0;
    assign alu_b        = (state_q == EXEC && dec_alu) ? dec_b : '0;
    assign alu_cont     = (state_q == EXEC && dec_alu) ? dec_cont : '0;
    assign rf_we        = rf_we_q;
    assign rf_waddr     = rf_waddr_q;
    assign rf_wdata     = rf_wdata_q;
    assign psr          = psr_q;
    assign branch_valid = branch_valid_q;
    assign branch_taken = branch_taken_q;
    assign branch_disp  = branch_disp_q;

endmodule

// File: tb/tb_instr_decoder.sv
// Bench for instr_decoder: register file and ALU stubs plus an instruction-level reference model.
module tb_instr_decoder;

    logic        clk = 1'b0;
    logic        reset;
    logic [15:0] instr;
    logic        instr_valid;
    logic        instr_ready;
    logic [3:0]  rf_raddr_a, rf_raddr_b, rf_waddr;
    logic [15:0] rf_rdata_a, rf_rdata_b, alu_a, alu_b, alu_out, psr_flags;
    logic [5:0]  alu_cont;
    logic        rf_we, branch_valid, branch_taken, illegal_instr;
    logic [15:0] rf_wdata, psr, branch_disp;

    logic [15:0] rf [16];
    logic [15:0] psr_m = 16'h0000;
    int tests = 0;
    int fails = 0;

    typedef struct packed {
        logic        alu;
        logic        br;
        logic        we;
        logic [5:0]  cont;
        logic [15:0] b;
        logic [15:0] mask;
    } exp_t;

    instr_decoder #(.WIDTH(16), .ALU_CONT_BITS(6)) dut (
        .clk(clk), .reset(reset), .instr(instr), .instr_valid(instr_valid),
        .instr_ready(instr_ready), .rf_raddr_a(rf_raddr_a), .rf_raddr_b(rf_raddr_b),
        .rf_rdata_a(rf_rdata_a), .rf_rdata_b(rf_rdata_b), .alu_a(alu_a), .alu_b(alu_b),
        .alu_cont(alu_cont), .alu_out(alu_out), .psr_flags(psr_flags), .rf_we(rf_we),
        .rf_waddr(rf_waddr), .rf_wdata(rf_wdata), .psr(psr), .branch_valid(branch_valid),
        .branch_taken(branch_taken), .branch_disp(branch_disp), .illegal_instr(illegal_instr)
    );

    always #5 clk = ~clk;

    // Behavioural ALU: returns {flags, result}; flag junk in unused bits checks PSR masking
    function automatic logic [31:0] alu_fn(input logic [5:0] cont, input logic [15:0] a, input logic [15:0] b);
        logic [16:0] s;
        logic [15:0] r, f, amt;
        s = 17'd0;
        amt = 16'd0 - b;
        case (cont)
            6'h01: r = a & b;
            6'h02: r = a | b;
            6'h03: r = a ^ b;
            6'h05, 6'h06: begin s = {1'b0, a} + {1'b0, b}; r = s[15:0]; end
            6'h09, 6'h0B: begin s = {1'b0, a} - {1'b0, b}; r = s[15:0]; end
            6'h0D: r = b;
            6'h25: r = b[15] ? (a >> amt[3:0]) : (a << b[3:0]);
            6'h3F: r = b << 8;
            default: r = 16'h0000;
        endcase
        f = {a[7:0] ^ b[7:0], 8'b0001_1010};
        f[0] = s[16];
        f[5] = (cont == 6'h05 || cont == 6'h06) ? (a[15] == b[15] && r[15] != a[15]) :
               (cont == 6'h09 || cont == 6'h0B) ? (a[15] != b[15] && r[15] != a[15]) : 1'b0;
        f[6] = (a == b);
        f[7] = ($signed(a) > $signed(b));
        f[2] = (a > b);
        return {f, r};
    endfunction

    assign rf_rdata_a = rf[rf_raddr_a];
    assign rf_rdata_b = rf[rf_raddr_b];
    assign {psr_flags, alu_out} = alu_fn(alu_cont, alu_a, alu_b);

    function automatic logic alu_code(input logic [3:0] c);
        logic [3:0] codes [8] = '{4'd1, 4'd2, 4'd3, 4'd5, 4'd6, 4'd9, 4'd11, 4'd13};
        for (int k = 0; k < 8; k++)
            if (codes[k] == c) return 1'b1;
        return 1'b0;
    endfunction

    function automatic exp_t model(input logic [15:0] i);
        exp_t e;
        logic [3:0] op, ext;
        op = i[15:12];
        ext = i[7:4];
        e = '0;
        if (op == 4'd0 && alu_code(ext)) begin
            e.alu = 1'b1; e.cont = {2'b00, ext}; e.b = rf[i[3:0]];
        end else if (op != 4'd0 && alu_code(op)) begin
            e.alu = 1'b1; e.cont = {2'b00, op};
            e.b = (op <= 4'd3) ? {8'h00, i[7:0]} : {{8{i[7]}}, i[7:0]};
        end else if (op == 4'd8 && ext == 4'd4) begin
            e.alu = 1'b1; e.cont = 6'b100101; e.b = rf[i[3:0]];
        end else if (op == 4'd8 && ext <= 4'd1) begin
            e.alu = 1'b1; e.cont = 6'b100101; e.b = {{11{i[4]}}, i[4:0]};
        end else if (op == 4'd15) begin
            e.alu = 1'b1; e.cont = 6'b111111; e.b = {8'h00, i[7:0]};
        end else if (op == 4'd12) begin
            e.br = 1'b1;
        end
        if (e.cont == 6'h05 || e.cont == 6'h09) e.mask = 16'h0021;
        if (e.cont == 6'h0B) e.mask = 16'h00C4;
        e.we = e.alu && (e.cont != 6'h0B);
        return e;
    endfunction

    function automatic logic cond_model(input logic [3:0] c, input logic [15:0] p);
        logic fc, fl, ff, fz, fn;
        {fn, fz, ff, fl, fc} = {p[7], p[6], p[5], p[2], p[0]};
        case (c)
            4'd0:  return fz;
            4'd1:  return !fz;
            4'd2:  return fc;
            4'd3:  return !fc;
            4'd4:  return fl;
            4'd5:  return !fl;
            4'd6:  return fn;
            4'd7:  return !fn;
            4'd8:  return ff;
            4'd9:  return !ff;
            4'd10: return !fl && !fz;
            4'd11: return fl || fz;
            4'd12: return !fn && !fz;
            4'd13: return fn || fz;
            4'd14: return 1'b1;
            default: return 1'b0;
        endcase
    endfunction

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] expv);
        tests++;
        assert (obs === expv) else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, expv);
        end
    endtask

    // Called at a falling edge while idle; returns at the falling edge of the next idle cycle
    task automatic issue(input logic [15:0] i, input logic hold_valid);
        exp_t e;
        logic [31:0] af;
        logic exp_taken, exp_ill;
        e = model(i);
        af = alu_fn(e.cont, rf[i[11:8]], e.b);
        exp_taken = cond_model(i[11:8], psr_m);
`ifdef INSTR_DECODER_ILLEGAL_TRAP_EN
        exp_ill = !(e.alu || e.br);
`else
        exp_ill = 1'b0;
`endif
        chk("ready_idle", instr_ready, 1'b1);
        instr = i;
        instr_valid = 1'b1;
        @(negedge clk);
        instr = 16'($urandom);
        instr_valid = hold_valid;
        chk("ready_exec", instr_ready, 1'b0);
        chk("alu_cont", alu_cont, e.alu ? e.cont : 6'd0);
        if (e.alu) begin
            chk("alu_a", alu_a, rf[i[11:8]]);
            chk("alu_b", alu_b, e.b);
        end
        @(negedge clk);
        psr_m = (psr_m & ~e.mask) | (af[31:16] & e.mask);
        chk("ready_wb", instr_ready, 1'b0);
        chk("rf_we", rf_we, e.we);
        if (e.we) begin
            chk("rf_waddr", rf_waddr, i[11:8]);
            chk("rf_wdata", rf_wdata, af[15:0]);
            rf[i[11:8]] = af[15:0];
        end
        chk("branch_valid", branch_valid, e.br);
        if (e.br) begin
            chk("branch_taken", branch_taken, exp_taken);
            chk("branch_disp", branch_disp, {{8{i[7]}}, i[7:0]});
        end
        chk("illegal_instr", illegal_instr, exp_ill);
        chk("psr", psr, psr_m);
        @(negedge clk);
        instr_valid = 1'b0;
        chk("ready_back", instr_ready, 1'b1);
        chk("we_cleared", rf_we, 1'b0);
        chk("bv_cleared", branch_valid, 1'b0);
        $display("[TB] instr %h alu=%0d br=%0d we=%0d psr=%h", i, e.alu, e.br, e.we, psr);
    endtask

    initial begin
        reset = 1'b1;
        instr_valid = 1'b0;
        instr = 16'h0000;
        for (int r = 0; r < 16; r++) rf[r] = 16'($urandom);
        repeat (2) @(negedge clk);
        chk("rst_ready", instr_ready, 1'b1);
        chk("rst_alu_cont", alu_cont, 6'd0);
        chk("rst_alu_a", alu_a, 16'h0);
        chk("rst_alu_b", alu_b, 16'h0);
        chk("rst_rf_we", rf_we, 1'b0);
        chk("rst_rf_waddr", rf_waddr, 4'd0);
        chk("rst_rf_wdata", rf_wdata, 16'h0);
        chk("rst_psr", psr, 16'h0);
        chk("rst_bv", branch_valid, 1'b0);
        chk("rst_bt", branch_taken, 1'b0);
        chk("rst_bd", branch_disp, 16'h0);
        chk("rst_illegal", illegal_instr, 1'b0);
        reset = 1'b0;
        @(negedge clk);

        rf[1] = 16'h7FFF;
        issue(16'h5101, 1'b0);
        chk("addi_wdata", rf_wdata, 16'h8000);
        chk("addi_psr_f", psr[5], 1'b1);
        chk("addi_psr_c", psr[0], 1'b0);

        rf[2] = 16'h0005;
        rf[3] = 16'h0005;
        issue(16'h02B3, 1'b1);
        chk("cmp_psr_z", psr[6], 1'b1);
        issue(16'hC0FC, 1'b1);

        issue(16'hF412, 1'b1);
        chk("lui_wdata", rf_wdata, 16'h1200);
        rf[5] = 16'h0010;
        issue(16'h851F, 1'b1);
        issue(16'h4000, 1'b1);

        // Abort an ADD in EXEC: nothing may be written and the PSR clears
        rf[1] = 16'hFFFF;
        rf[2] = 16'h0001;
        instr = 16'h0152;
        instr_valid = 1'b1;
        @(negedge clk);
        instr_valid = 1'b0;
        chk("abort_exec_cont", alu_cont, 6'h05);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        psr_m = 16'h0000;
        chk("abort_ready", instr_ready, 1'b1);
        chk("abort_we", rf_we, 1'b0);
        chk("abort_psr", psr, 16'h0);
        @(negedge clk);
        chk("abort_we_after", rf_we, 1'b0);
        chk("abort_bv_after", branch_valid, 1'b0);
        $display("[TB] reset during EXEC of %h", 16'h0152);

        for (int n = 0; n < 80; n++) begin
            rf[$urandom_range(0, 15)] = 16'($urandom);
            issue(16'($urandom), 1'($urandom_range(0, 1)));
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/instr_decoder.md
# instr_decoder

Multi-cycle decode/issue controller that drives the ALU/register-file datapath. It accepts one 16-bit instruction over a valid/ready handshake and performs these steps:
- reads operands from the register file;
- drives `alu_a`, `alu_b` and `alu_cont` into the ALU;
- captures the ALU result and the relevant `psr_flags` bits into a local PSR;
- issues register writeback or a Bcond branch resolution.

It is the producer of the ALU control word and the consumer of the ALU's result and flags.

## Interface
Parameters:
- `WIDTH`, 16, datapath width.
- `ALU_CONT_BITS`, 6, ALU control width: `{category[1:0], opcode[3:0]}`.

Ports:
- `clk`  in  1  system clock, rising edge.
- `reset`  in  1  synchronous, active-high.
- `instr`  in  16  instruction word.
- `instr_valid`  in  1  instruction offered.
- `instr_ready`  out  1  high only in IDLE.
- `rf_raddr_a`  out  4  register read address, = Rdest `instr[11:8]`.
- `rf_raddr_b`  out  4  register read address, = Rsrc `instr[3:0]`.
- `rf_rdata_a`, `rf_rdata_b`  in  WIDTH  combinational register-file read data.
- `alu_a`, `alu_b`  out  WIDTH  ALU operands.
- `alu_cont`  out  ALU_CONT_BITS  ALU operation select.
- `alu_out`  in  WIDTH  ALU result.
- `psr_flags`  in  WIDTH  ALU flags, bit layout: C=0, L=2, F=5, Z=6, N=7.
- `rf_we`  out  1  writeback strobe.
- `rf_waddr`  out  4  writeback address.
- `rf_wdata`  out  WIDTH  writeback data.
- `psr`  out  WIDTH  registered PSR, same bit layout as `psr_flags`, other bits 0.
- `branch_valid`  out  1  one-cycle Bcond resolution pulse.
- `branch_taken`  out  1  Bcond condition result.
- `branch_disp`  out  WIDTH  sign-extended `instr[7:0]`.
- `illegal_instr`  out  1  one-cycle pulse on undefined opcode.

## Operation
Instruction fields: `op=[15:12]`, `rd=[11:8]`, `ext=[7:4]`, `rs=[3:0]`, `imm=[7:0]`. The accepted instruction is latched and held until WB completes.

Decode:
- **op=0000 (R-type):** `alu_cont={00,ext}`, b=`rf_rdata_b`. Legal ext values: 0001, 0010, 0011, 0101, 0110, 1001, 1011, 1101.
- **Immediate ops, op ∈ {0001, 0010, 0011, 0101, 0110, 1001, 1011, 1101}:** `alu_cont={00,op}`.
  - b = zero-extended imm for op 0001–0011.
  - b = sign-extended imm otherwise.
- **op=1000 (shift):**
  - ext=0100 (LSH): `alu_cont=100101`, b=`rf_rdata_b`.
  - ext=000x (LSHI): `alu_cont=100101`, b = sign-extended `instr[4:0]`.
- **op=1111 (LUI):** `alu_cont=111111`, b = zero-extended imm.
- **op=1100 (Bcond):** no ALU operation. cond=`rd`.
- Everything else is undefined.
- a = `rf_rdata_a` for every ALU operation.

State machine IDLE → EXEC → WB → IDLE:
- **IDLE:** `instr_ready=1`, `alu_cont=0`. When `instr_valid` is high, latch `instr` and go to EXEC.
- **EXEC:** drive the decoded `alu_a`, `alu_b` and `alu_cont`. On the clock edge leaving EXEC:
  - register `alu_out` into `rf_wdata`;
  - update the PSR from `psr_flags`, by instruction:
    - ADD/ADDI/SUB/SUBI: C and F;
    - CMP/CMPI: N, Z and L;
    - any other instruction: PSR unchanged.
- **WB:** one of the following, then IDLE.
  - Writeback: `rf_we=1` with `rf_waddr=rd`, except for CMP, CMPI, Bcond and undefined opcodes.
  - Bcond: `branch_valid=1`. `branch_taken` is evaluated against the PSR as it stood before this instruction.

Bcond cond codes:

| cond | mnemonic | taken when |
|---|---|---|
| 0000 | EQ | Z |
| 0001 | NE | !Z |
| 0010 | CS | C |
| 0011 | CC | !C |
| 0100 | HI | L |
| 0101 | LS | !L |
| 0110 | GT | N |
| 0111 | LE | !N |
| 1000 | FS | F |
| 1001 | FC | !F |
| 1010 | LO | !L & !Z |
| 1011 | HS | L \| Z |
| 1100 | LT | !N & !Z |
| 1101 | GE | N \| Z |
| 1110 | UC | always |
| 1111 | — | never |

## Timing
- Fixed 3-cycle occupancy; throughput is one instruction per 3 cycles.
  - Handshake at cycle 0.
  - `rf_we` / `branch_valid` high in cycle 2 only.
  - `instr_ready` high again in cycle 3.
- The `instr` value is ignored unless the handshake occurs.
- `instr_valid` may stay high across instructions; back-to-back acceptance happens every 3rd cycle.
- A PSR update is visible at `psr` in the cycle WB begins. A Bcond accepted immediately after a CMP sees that CMP's flags.
- Reset values:
  - outputs: `instr_ready=1` (IDLE), `alu_a=alu_b=0`, `alu_cont=0`, `rf_we=0`, `rf_waddr=0`, `rf_wdata=0`, `psr=0`, `branch_valid=0`, `branch_taken=0`, `branch_disp=0`, `illegal_instr=0`;
  - state: IDLE.
- Reset asserted in any state, including EXEC and WB, returns to IDLE the next edge and discards the latched instruction. No `rf_we` or `branch_valid` is issued for the aborted instruction.

## Configuration
- **`INSTR_DECODER_ILLEGAL_TRAP_EN` defined:** undefined opcodes pulse `illegal_instr` in WB. No writeback, no PSR change, no branch.
- **Not defined:** undefined opcodes execute as NOP. `alu_cont=0`, same 3-cycle flow, no writeback, no PSR change, `illegal_instr` tied 0.

## Test plan
- **ADDI overflow:** r1=0x7FFF, `instr=0x5101` → EXEC `alu_cont=000101`, `alu_b=0x0001`; WB `rf_we=1`, `rf_waddr=1`, `rf_wdata=0x8000`; `psr` F=1, C=0.
- **CMP then BEQ:** r2=r3=0x0005, `instr=0x02B3` → no `rf_we`, `psr` Z=1. Then `instr=0xC0FC` → `branch_valid=1`, `branch_taken=1`, `branch_disp=0xFFFC`.
- **LUI / LSHI:**
  - `instr=0xF412` → `rf_wdata=0x1200` to r4.
  - r5=0x0010, `instr=0x851F` → `alu_b=0xFFFF`, `alu_cont=100101`.
- **Handshake:** `instr_valid` held high with 3 instructions → accepts at cycles 0, 3, 6; `instr_ready` low in cycles 1–2, 4–5.
- **Reset mid-EXEC:** reset during EXEC of ADD → no `rf_we`, `psr=0`, `instr_ready=1` the next cycle.
- **Undefined op:** `instr=0x4000` → with the macro, `illegal_instr` pulses in WB; without it, no pulse. In both cases no `rf_we` and `psr` unchanged.
